pwm_gen_multi: RTL and testbench

Multi-channel programmable waveform generator: each channel produces a rectangular wave with independently programmed high and low durations, counted in prescaler ticks. Channels run continuously, for one period, or for an N-period burst, with glitch-free reprogramming at period boundaries. The block sits behind the system prescaler, which supplies `tick`, and drives the waveform pins and the timing-capture logic.

---
 rtl/pwm_gen_pkg.sv | 29 ++
 rtl/pwm_gen_multi_chan.sv | 153 +++++++++++++++
 rtl/pwm_gen_multi.sv | 54 +++++
 tb/tb_pwm_gen_multi.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared types for the multi-channel waveform generator.
// Contents: channel state enum, run-mode encodings, per-channel configuration struct.
// Field widths here set the duration and burst widths used by every channel.
package pwm_gen_pkg;

    // Duration (high/low) and burst-count field widths carried in cfg_t.
    localparam int PWM_WIDTH   = 8;
    localparam int PWM_BURST_W = 8;

    // Run modes; encoding 3 is reserved and behaves as continuous.
    localparam logic [1:0] MODE_CONT    = 2'd0;
    localparam logic [1:0] MODE_ONESHOT = 2'd1;
    localparam logic [1:0] MODE_BURST   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PWM_WIDTH-1:0]   high;   // high-phase duration, ticks
        logic [PWM_WIDTH-1:0]   low;    // low-phase duration, ticks
        logic [1:0]             mode;   // MODE_* encoding
        logic [PWM_BURST_W-1:0] count;  // periods per burst
        logic                   pol;    // 1 inverts output and idle level
    } cfg_t;

endpackage

// File: rtl/pwm_gen_multi_chan.sv
// One waveform channel: shadow/active config, IDLE/HIGH/LOW FSM, phase and period counters.
// Ports: clk/reset, i_tick enable, i_we + i_cfg shadow write, i_start/i_stop, o_wave/o_busy/o_done.
// Outputs are registered; start->wave/busy is one clock. Config is latched into the active set at each HIGH entry.
module pwm_chan
    import pwm_gen_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_we,
    input  cfg_t i_cfg,
    input  logic i_start,
    input  logic i_stop,
    output logic o_wave,
    output logic o_busy,
    output logic o_done
);

    cfg_t                   r_shadow;
    cfg_t                   r_act;
    state_t                 r_state;
    logic [PWM_WIDTH-1:0]   r_cnt;
    logic [PWM_BURST_W-1:0] r_pcnt;
    logic                   r_wave;
    logic                   r_done;

    cfg_t                   w_eff;
    cfg_t                   w_act_nxt;
    state_t                 w_state_nxt;
    logic [PWM_WIDTH-1:0]   w_cnt_nxt;
    logic [PWM_BURST_W-1:0] w_pcnt_nxt;
    logic                   w_done_nxt;
    state_t                 w_ent_state;
    logic [PWM_WIDTH-1:0]   w_ent_cnt;
    logic                   w_start_ok;
    logic                   w_period_end;
    logic                   w_unused_act;

    // A write in the same cycle as a start or period boundary is used directly,
    // so the new values take effect without waiting a cycle for the shadow.
    assign w_eff = i_we ? i_cfg : r_shadow;

    // Where a new period begins: zero high skips straight to LOW, zero high
    // and low together leaves nothing to run.
    always_comb begin
        w_ent_state = ST_IDLE;
        w_ent_cnt   = '0;
        if (w_eff.high != '0) begin
            w_ent_state = ST_HIGH;
            w_ent_cnt   = w_eff.high - 1'b1;
        end else if (w_eff.low != '0) begin
            w_ent_state = ST_LOW;
            w_ent_cnt   = w_eff.low - 1'b1;
        end
    end

    assign w_start_ok = (w_ent_state != ST_IDLE) &&
                        !((w_eff.mode == MODE_BURST) && (w_eff.count == '0));

    // End of a period: tick at counter zero in LOW, or in HIGH when low=0.
    assign w_period_end = i_tick && (r_cnt == '0) &&
                          ((r_state == ST_LOW) ||
                           ((r_state == ST_HIGH) && (r_act.low == '0)));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pcnt_nxt  = r_pcnt;
        w_act_nxt   = r_act;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start && w_start_ok) begin
                    w_state_nxt = w_ent_state;
                    w_cnt_nxt   = w_ent_cnt;
                    w_pcnt_nxt  = w_eff.count;
                    w_act_nxt   = w_eff;
                end
            end
            ST_HIGH, ST_LOW: begin
                if (w_period_end) begin
                    if (r_act.mode == MODE_ONESHOT ||
                        (r_act.mode == MODE_BURST && r_pcnt <= PWM_BURST_W'(1))) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        if (r_act.mode == MODE_BURST) begin
                            w_pcnt_nxt = r_pcnt - 1'b1;
                        end
                        // Reprogrammed to 0/0 while running: nothing left to
                        // generate, so the channel falls idle without done.
                        w_state_nxt = w_ent_state;
                        w_cnt_nxt   = w_ent_cnt;
                        w_act_nxt   = w_eff;
                    end
                end else if (i_tick) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end else begin
                        // HIGH finished with a non-zero LOW phase to follow.
                        w_state_nxt = ST_LOW;
                        w_cnt_nxt   = r_act.low - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Abort overrides everything, including a coincident start or completion.
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_pcnt   <= '0;
            r_shadow <= '0;
            r_act    <= '0;
            r_wave   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_act   <= w_act_nxt;
            r_done  <= w_done_nxt;
            if (i_we) begin
                r_shadow <= i_cfg;
            end
            // Polarity tracks the shadow register at all times, even in IDLE.
            r_wave <= (w_state_nxt == ST_HIGH) ^ w_eff.pol;
        end
    end

    // Active high/count/pol are latched with the rest of the set but only
    // low and mode are consulted mid-period.
    assign w_unused_act = ^{r_act.high, r_act.count, r_act.pol};

    assign o_wave = r_wave;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel programmable rectangular-wave generator (CHANNELS x pwm_chan).
// Ports: clk/reset, tick, cfg_we/cfg_ch + cfg fields, start/stop vectors; wave/busy/done per channel.
// One clock from start to wave/busy; top only decodes cfg_ch and fans the config bus out.
module pwm_gen_multi
    import pwm_gen_pkg::*;
#(
    parameter int CHANNELS = 4,
    // WIDTH and BURST_W size the ports and must equal PWM_WIDTH / PWM_BURST_W.
    parameter int WIDTH    = PWM_WIDTH,
    parameter int BURST_W  = PWM_BURST_W,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_high,
    input  logic [WIDTH-1:0]    cfg_low,
    input  logic [1:0]          cfg_mode,
    input  logic [BURST_W-1:0]  cfg_count,
    input  logic                cfg_pol,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] wave,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    cfg_t w_cfg;

    assign w_cfg = '{high: cfg_high, low: cfg_low, mode: cfg_mode,
                     count: cfg_count, pol: cfg_pol};

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic w_we;

        assign w_we = cfg_we && (cfg_ch == CH_W'(gi));

        pwm_chan u_chan (
            .clk     (clk),
            .reset   (reset),
            .i_tick  (tick),
            .i_we    (w_we),
            .i_cfg   (w_cfg),
            .i_start (start[gi]),
            .i_stop  (stop[gi]),
            .o_wave  (wave[gi]),
            .o_busy  (busy[gi]),
            .o_done  (done[gi])
        );
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
module tb_pwm_gen_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_count;
    logic       cfg_pol;
    logic [3:0] start;
    logic [3:0] stop;
    logic [3:0] wave;
    logic [3:0] busy;
    logic [3:0] done;

    int n_pass  = 0;
    int n_total = 0;

    pwm_gen_multi u_dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
        .cfg_mode  (cfg_mode),
        .cfg_count (cfg_count),
        .cfg_pol   (cfg_pol),
        .start     (start),
        .stop      (stop),
        .wave      (wave),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] start;
        logic [3:0] stop;
        logic       tick;
        logic       we;
        logic [1:0] ch;
        logic [7:0] high;
        logic [7:0] low;
        logic [1:0] mode;
        logic [7:0] count;
        logic       pol;
        logic [3:0] exp_wave;
        logic [3:0] exp_busy;
        logic [3:0] exp_done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] st, input logic [3:0] sp, input logic tk,
                               input logic we, input logic [1:0] ch, input logic [7:0] hi,
                               input logic [7:0] lo, input logic [1:0] md, input logic [7:0] cn,
                               input logic pl, input logic [3:0] ew, input logic [3:0] eb,
                               input logic [3:0] ed);
        vec_t r;
        r.start = st; r.stop = sp; r.tick = tk; r.we = we; r.ch = ch;
        r.high = hi; r.low = lo; r.mode = md; r.count = cn; r.pol = pl;
        r.exp_wave = ew; r.exp_busy = eb; r.exp_done = ed;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, req);
    endtask

    task automatic set_cfg(input logic we, input logic [1:0] ch, input logic [7:0] hi,
                           input logic [7:0] lo, input logic [1:0] md, input logic [7:0] cn,
                           input logic pl);
        cfg_we = we; cfg_ch = ch; cfg_high = hi; cfg_low = lo;
        cfg_mode = md; cfg_count = cn; cfg_pol = pl;
    endtask

    // Advance one rising edge, then compare all three output vectors.
    task automatic step_chk(input string nm, input logic [3:0] ew, input logic [3:0] eb,
                            input logic [3:0] ed);
        @(posedge clk);
        #1;
        chk({nm, " wave"}, wave, ew);
        chk({nm, " busy"}, busy, eb);
        chk({nm, " done"}, done, ed);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; start = '0; stop = '0;
        set_cfg(1'b0, 2'd0, 8'd0, 8'd0, 2'd0, 8'd0, 1'b0);

        // ---- reset state ----
        @(posedge clk);
        step_chk("reset", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;

        // ---- table: continuous 3/2 on ch0, reprogram mid-HIGH, conflicts, zero cases ----
        //               start  stop  tk we ch  hi  lo  md cnt pol  wave    busy    done
        tbl.push_back(v(4'h0, 4'h0, 0, 1, 0, 3, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(4'h1, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e1
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e2
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e3
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e4
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e5
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e6
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e7
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e8
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e9
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e10
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 3, 2, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e11
        tbl.push_back(v(4'h0, 4'h0, 1, 1, 0, 1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e12 rewrite 1/1
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e13
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e14
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e15
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e16 new 1/1
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e17
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0001, 4'b0001, 4'b0000)); // e18
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000)); // e19 LOW
        tbl.push_back(v(4'h0, 4'h1, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000)); // stop mid-LOW
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(4'h1, 4'h1, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000)); // start+stop
        tbl.push_back(v(4'h0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(v(4'h1, 4'h0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000)); // 0/0 bypass
        tbl.push_back(v(4'h1, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000)); // 0/0 shadow
        tbl.push_back(v(4'h1, 4'h0, 1, 1, 0, 1, 1, 2, 0, 0, 4'b0000, 4'b0000, 4'b0000)); // burst cnt 0

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            tick  = tbl[i].tick;
            set_cfg(tbl[i].we, tbl[i].ch, tbl[i].high, tbl[i].low, tbl[i].mode,
                    tbl[i].count, tbl[i].pol);
            step_chk($sformatf("vec%0d", i), tbl[i].exp_wave, tbl[i].exp_busy,
                     tbl[i].exp_done);
        end
        start = '0; stop = '0; tick = 1'b0;

        // ---- one-shot ch1, 2/1, tick every 4th cycle; tick at start not counted ----
        set_cfg(1'b1, 2'd1, 8'd2, 8'd1, 2'd1, 8'd0, 1'b0);
        step_chk("os_cfg", 4'b0000, 4'b0000, 4'b0000);
        cfg_we = 1'b0;
        start = 4'b0010; tick = 1'b1;
        step_chk("os_start", 4'b0010, 4'b0010, 4'b0000);
        for (int n = 1; n <= 13; n++) begin
            start = (n == 2) ? 4'b0010 : 4'b0000;   // restart while busy: ignored
            tick  = (n % 4 == 0);
            step_chk($sformatf("os_n%0d", n),
                     (n < 8)   ? 4'b0010 : 4'b0000,
                     (n < 12)  ? 4'b0010 : 4'b0000,
                     (n == 12) ? 4'b0010 : 4'b0000);
        end

        // ---- burst ch2, count 3, 1/1, tick held high ----
        tick = 1'b1; start = '0;
        set_cfg(1'b1, 2'd2, 8'd1, 8'd1, 2'd2, 8'd3, 1'b0);
        step_chk("bu_cfg", 4'b0000, 4'b0000, 4'b0000);
        cfg_we = 1'b0;
        start = 4'b0100;
        step_chk("bu_start", 4'b0100, 4'b0100, 4'b0000);
        start = '0;
        for (int n = 1; n <= 7; n++) begin
            step_chk($sformatf("bu_n%0d", n),
                     (n % 2 == 0 && n < 6) ? 4'b0100 : 4'b0000,
                     (n < 6)  ? 4'b0100 : 4'b0000,
                     (n == 6) ? 4'b0100 : 4'b0000);
        end

        // ---- polarity ch3, 2/2 continuous, then reset mid-period ----
        set_cfg(1'b1, 2'd3, 8'd2, 8'd2, 2'd0, 8'd0, 1'b1);
        step_chk("pol_idle", 4'b1000, 4'b0000, 4'b0000);
        cfg_we = 1'b0;
        start = 4'b1000;
        step_chk("pol_e0", 4'b0000, 4'b1000, 4'b0000);
        start = '0;
        step_chk("pol_e1", 4'b0000, 4'b1000, 4'b0000);
        step_chk("pol_e2", 4'b1000, 4'b1000, 4'b0000);
        step_chk("pol_e3", 4'b1000, 4'b1000, 4'b0000);
        step_chk("pol_e4", 4'b0000, 4'b1000, 4'b0000);
        reset = 1'b1;
        step_chk("rst_mid", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        step_chk("rst_after", 4'b0000, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
